vdp_bus_bridge: RTL

- Upstream front end of vdp_inst.
- Takes the asynchronous, slow Z80 cartridge I/O bus, synchronises it into the 42.95454 MHz clk domain and decodes VDP ports 98h/99h.
- Converts each bus access into exactly one clean VDP CPU-port transaction: iorq_n/wr_n/rd_n strobes, address bit, write data.
- Captures read data on vdp_rdata_en and holds it on the bus until the Z80 releases RD.

---
 rtl/vdp_bus_bridge.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/vdp_bus_bridge.sv
// Z80 cartridge I/O bus to VDP CPU-port bridge: synchronises the slow asynchronous
// bus strobes and turns each decoded access into exactly one clean VDP transaction.
module vdp_bus_bridge #(
    parameter logic [7:0] IO_BASE       = 8'h98,
    parameter int         STROBE_CYCLES = 2,
    parameter int         READ_TIMEOUT  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       bus_iorq_n,
    input  logic       bus_rd_n,
    input  logic       bus_wr_n,
    input  logic [7:0] bus_address,
    input  logic [7:0] bus_wdata,
    output logic [7:0] bus_rdata,
    output logic       bus_rdata_oe,
    output logic       bus_wait_n,
    output logic       vdp_iorq_n,
    output logic       vdp_wr_n,
    output logic       vdp_rd_n,
    output logic       vdp_address,
    output logic [7:0] vdp_wdata,
    input  logic [7:0] vdp_rdata,
    input  logic       vdp_rdata_en
);

    typedef enum logic [2:0] {
        IDLE,
        WR_STROBE,
        RD_STROBE,
        RD_HOLD,
        WAIT_RELEASE
    } state_t;

    localparam logic [7:0] STROBE_LOAD  = 8'(STROBE_CYCLES);
    localparam logic [7:0] TIMEOUT_LOAD = 8'(READ_TIMEOUT);

    state_t     state, state_next;
    logic [1:0] iorq_sync, rd_sync, wr_sync;
    logic [1:0] settle;
    logic       armed, armed_next;
    logic [7:0] count, count_next;
    logic       iorq_n_next, wr_n_next, rd_n_next, address_next;
    logic       wait_n_next, oe_next;
    logic [7:0] wdata_next, rdata_next;
    logic       s_iorq, s_rd, s_wr, hit, released;

    // settle marks when the synchronisers reflect the live bus again after reset
    always_ff @(posedge clk) begin
        if (reset) begin
            iorq_sync <= 2'b11;
            rd_sync   <= 2'b11;
            wr_sync   <= 2'b11;
            settle    <= 2'b00;
        end else begin
            iorq_sync <= {iorq_sync[0], bus_iorq_n};
            rd_sync   <= {rd_sync[0], bus_rd_n};
            wr_sync   <= {wr_sync[0], bus_wr_n};
            settle    <= {settle[0], 1'b1};
        end
    end

    assign s_iorq   = ~iorq_sync[1];
    assign s_rd     = ~rd_sync[1];
    assign s_wr     = ~wr_sync[1];
    assign hit      = s_iorq & (bus_address[7:1] == IO_BASE[7:1]);
    assign released = ~s_iorq | (~s_rd & ~s_wr);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            armed        <= 1'b0;
            count        <= 8'd0;
            vdp_iorq_n   <= 1'b1;
            vdp_wr_n     <= 1'b1;
            vdp_rd_n     <= 1'b1;
            vdp_address  <= 1'b0;
            vdp_wdata    <= 8'h00;
            bus_rdata    <= 8'hFF;
            bus_rdata_oe <= 1'b0;
            bus_wait_n   <= 1'b1;
        end else begin
            state        <= state_next;
            armed        <= armed_next;
            count        <= count_next;
            vdp_iorq_n   <= iorq_n_next;
            vdp_wr_n     <= wr_n_next;
            vdp_rd_n     <= rd_n_next;
            vdp_address  <= address_next;
            vdp_wdata    <= wdata_next;
            bus_rdata    <= rdata_next;
            bus_rdata_oe <= oe_next;
            bus_wait_n   <= wait_n_next;
        end
    end

    always_comb begin
        state_next   = state;
        armed_next   = armed;
        count_next   = count;
        iorq_n_next  = vdp_iorq_n;
        wr_n_next    = vdp_wr_n;
        rd_n_next    = vdp_rd_n;
        address_next = vdp_address;
        wdata_next   = vdp_wdata;
        rdata_next   = bus_rdata;
        oe_next      = bus_rdata_oe;
        wait_n_next  = bus_wait_n;

        case (state)
            IDLE: begin
                // First pass after reset: a Z80 cycle caught mid-flight must end before any new access
                if (!armed) begin
                    if (settle[1]) begin
                        armed_next = 1'b1;
                        state_next = WAIT_RELEASE;
                    end
                end else if (hit & s_wr & ~s_rd) begin
                    address_next = bus_address[0];
                    wdata_next   = bus_wdata;
                    iorq_n_next  = 1'b0;
                    wr_n_next    = 1'b0;
                    count_next   = STROBE_LOAD;
                    state_next   = WR_STROBE;
                end else if (hit & s_rd & ~s_wr) begin
                    address_next = bus_address[0];
                    iorq_n_next  = 1'b0;
                    rd_n_next    = 1'b0;
                    wait_n_next  = 1'b0;
                    count_next   = TIMEOUT_LOAD;
                    state_next   = RD_STROBE;
                end else if (hit & s_rd & s_wr) begin
                    state_next = WAIT_RELEASE;
                end
            end
            WR_STROBE: begin
                if (count == 8'd1) begin
                    iorq_n_next = 1'b1;
                    wr_n_next   = 1'b1;
                    state_next  = WAIT_RELEASE;
                end else begin
                    count_next = count - 8'd1;
                end
            end
            RD_STROBE: begin
                if (vdp_rdata_en || (count == 8'd1)) begin
                    rdata_next  = vdp_rdata_en ? vdp_rdata : 8'hFF;
                    iorq_n_next = 1'b1;
                    rd_n_next   = 1'b1;
                    wait_n_next = 1'b1;
                    oe_next     = 1'b1;
                    state_next  = RD_HOLD;
                end else begin
                    count_next = count - 8'd1;
                end
            end
            RD_HOLD: begin
                if (!(s_rd & s_iorq)) begin
                    oe_next    = 1'b0;
                    state_next = IDLE;
                end
            end
            WAIT_RELEASE: begin
                if (released) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
